// File: rtl/adc_capture_pkg.sv
// Shared types and defaults for the ADC capture deadlock watchdog.
package adc_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SUSPECT  = 2'd1,
    ST_DEADLOCK = 2'd2
  } wd_state_e;

  localparam int unsigned DEFAULT_CNT_W = 16;

endpackage

// File: rtl/adc_capture_block_reduce.sv
// Combinational reduction of stream/sub-monitor block flags and process idles into
// the raw block condition; also usable standalone by the per-process monitors.
module adc_capture_block_reduce
  import adc_capture_pkg::*;
#(
  parameter int unsigned N_AXIS = 2,
  parameter int unsigned N_SUB  = 3,
  parameter int unsigned N_INST = 5
) (
  input  logic [N_AXIS-1:0]                axis_block_sigs,
  input  logic [((N_SUB>0)?N_SUB:1)-1:0]   sub_block_sigs,
  input  logic [N_INST-1:0]                inst_idle_sigs,
  output logic                             sub_term,
  output logic                             raw
);

  // With no sub-monitors the single unused input bit is ignored entirely.
  always_comb begin
    sub_term = (N_SUB > 0) && (&sub_block_sigs);
    raw      = ((|axis_block_sigs) | sub_term) & ~(&inst_idle_sigs);
  end

endmodule

// File: rtl/adc_capture_deadlock_watchdog.sv
// Deadlock watchdog for the capture dataflow: requires the block condition to persist
// for a programmable number of cycles before flagging deadlock; captures cause and counts events.
module adc_capture_deadlock_watchdog
  import adc_capture_pkg::*;
#(
  parameter int unsigned N_AXIS = 2,
  parameter int unsigned N_SUB  = 3,
  parameter int unsigned N_INST = 5,
  parameter int unsigned CNT_W  = DEFAULT_CNT_W,
  parameter int unsigned STICKY = 1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [N_AXIS-1:0]                axis_block_sigs,
  input  logic [((N_SUB>0)?N_SUB:1)-1:0]   sub_block_sigs,
  input  logic [N_INST-1:0]                inst_idle_sigs,
  input  logic [CNT_W-1:0]                 threshold,
  input  logic                             clear,
  output logic                             block,
  output logic                             deadlock,
  output logic [1:0]                       state,
  output logic [N_AXIS:0]                  cause,
  output logic [CNT_W-1:0]                 block_cycles,
  output logic [7:0]                       event_count
);

  logic              raw;
  logic              sub_term;
  wd_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  teff;
  logic [CNT_W-1:0]  cnt_sat;
  logic [CNT_W:0]    cnt_plus1;
  logic              reach;
  logic [N_AXIS:0]   cause_q, cause_d;
  logic [7:0]        evt_q, evt_d;
  logic              block_q;

  adc_capture_block_reduce #(
    .N_AXIS (N_AXIS),
    .N_SUB  (N_SUB),
    .N_INST (N_INST)
  ) u_reduce (
    .axis_block_sigs (axis_block_sigs),
    .sub_block_sigs  (sub_block_sigs),
    .inst_idle_sigs  (inst_idle_sigs),
    .sub_term        (sub_term),
    .raw             (raw)
  );

  // Compare in CNT_W+1 bits so cnt+1 cannot wrap against a full-scale threshold.
  always_comb begin
    teff      = (threshold == '0) ? CNT_W'(1) : threshold;
    cnt_plus1 = {1'b0, cnt_q} + (CNT_W+1)'(1);
    cnt_sat   = (&cnt_q) ? cnt_q : cnt_plus1[CNT_W-1:0];
    reach     = (cnt_plus1 >= {1'b0, teff});
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    evt_d   = evt_q;

    if (clear) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      cause_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (raw) begin
            cnt_d   = CNT_W'(1);
            cause_d = {sub_term, axis_block_sigs};
            state_d = (teff == CNT_W'(1)) ? ST_DEADLOCK : ST_SUSPECT;
          end else begin
            cnt_d = '0;
          end
        end
        ST_SUSPECT: begin
          if (!raw) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            cause_d = '0;
          end else begin
            cnt_d = cnt_sat;
            if (reach) state_d = ST_DEADLOCK;
          end
        end
        ST_DEADLOCK: begin
          if (raw) begin
            cnt_d = cnt_sat;
          end else if (STICKY == 0) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            cause_d = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          cause_d = '0;
        end
      endcase
    end

    if ((state_d == ST_DEADLOCK) && (state_q != ST_DEADLOCK) && (evt_q != '1))
      evt_d = evt_q + 8'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cause_q <= '0;
      evt_q   <= '0;
      block_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      evt_q   <= evt_d;
      block_q <= raw;
    end
  end

  always_comb begin
    block        = block_q;
    deadlock     = (state_q == ST_DEADLOCK);
    state        = state_q;
    cause        = cause_q;
    block_cycles = cnt_q;
    event_count  = evt_q;
  end

endmodule

// File: tb/tb_adc_capture_deadlock_watchdog.sv
// Scoreboard bench: sticky and non-sticky watchdogs share stimulus; a cycle model predicts outputs.
module tb_adc_capture_deadlock_watchdog;

  typedef struct packed {
    logic [1:0] st;
    logic [3:0] cnt;
    logic [2:0] cause;
    logic [7:0] evt;
    logic       blk;
  } mdl_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       clear;
  logic [1:0] axis;
  logic [2:0] sub;
  logic [4:0] idle;
  logic [3:0] thr;

  logic       a_block, a_deadlock, b_block, b_deadlock;
  logic [1:0] a_state, b_state;
  logic [2:0] a_cause, b_cause;
  logic [3:0] a_bc, b_bc;
  logic [7:0] a_evt, b_evt;

  int   n_vec = 0;
  int   n_miscmp = 0;
  mdl_t m_a, m_b;
  mdl_t exp_q[$];

  always #5 clock = ~clock;

  adc_capture_deadlock_watchdog #(
    .N_AXIS (2), .N_SUB (3), .N_INST (5), .CNT_W (4), .STICKY (1)
  ) u_sticky (
    .clock (clock), .reset (reset),
    .axis_block_sigs (axis), .sub_block_sigs (sub), .inst_idle_sigs (idle),
    .threshold (thr), .clear (clear),
    .block (a_block), .deadlock (a_deadlock), .state (a_state), .cause (a_cause),
    .block_cycles (a_bc), .event_count (a_evt)
  );

  adc_capture_deadlock_watchdog #(
    .N_AXIS (2), .N_SUB (3), .N_INST (5), .CNT_W (4), .STICKY (0)
  ) u_nonsticky (
    .clock (clock), .reset (reset),
    .axis_block_sigs (axis), .sub_block_sigs (sub), .inst_idle_sigs (idle),
    .threshold (thr), .clear (clear),
    .block (b_block), .deadlock (b_deadlock), .state (b_state), .cause (b_cause),
    .block_cycles (b_bc), .event_count (b_evt)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Behavioural model of one clock edge given the currently driven inputs.
  function automatic mdl_t model_step(input mdl_t m, input bit sticky);
    mdl_t n;
    logic subt, raw;
    int   teff;
    subt = &sub;
    raw  = ((|axis) | subt) & ~(&idle);
    teff = (thr == 4'd0) ? 1 : int'(thr);
    if (reset) return '0;
    n     = m;
    n.blk = raw;
    if (clear) begin
      n.st = 2'd0; n.cnt = 4'd0; n.cause = 3'd0;
      return n;
    end
    case (m.st)
      2'd0: if (raw) begin
        n.cause = {subt, axis};
        n.cnt   = 4'd1;
        n.st    = (teff == 1) ? 2'd2 : 2'd1;
      end else n.cnt = 4'd0;
      2'd1: if (!raw) begin
        n.st = 2'd0; n.cnt = 4'd0; n.cause = 3'd0;
      end else begin
        if (int'(m.cnt) + 1 >= teff) n.st = 2'd2;
        n.cnt = (m.cnt == 4'd15) ? 4'd15 : m.cnt + 4'd1;
      end
      default: if (raw) n.cnt = (m.cnt == 4'd15) ? 4'd15 : m.cnt + 4'd1;
        else if (!sticky) begin
          n.st = 2'd0; n.cnt = 4'd0; n.cause = 3'd0;
        end
    endcase
    if (n.st == 2'd2 && m.st != 2'd2 && m.evt != 8'd255) n.evt = m.evt + 8'd1;
    return n;
  endfunction

  task automatic cmp_outs(input string who, input mdl_t e, input logic blk, input logic dl,
                          input logic [1:0] st, input logic [2:0] ca, input logic [3:0] bc,
                          input logic [7:0] ev);
    check_val({who, ".block"}, 32'(blk), 32'(e.blk));
    check_val({who, ".deadlock"}, 32'(dl), 32'(e.st == 2'd2));
    check_val({who, ".state"}, 32'(st), 32'(e.st));
    check_val({who, ".cause"}, 32'(ca), 32'(e.cause));
    check_val({who, ".block_cycles"}, 32'(bc), 32'(e.cnt));
    check_val({who, ".event_count"}, 32'(ev), 32'(e.evt));
  endtask

  task automatic step_cycle();
    mdl_t ea, eb;
    ea = model_step(m_a, 1'b1);
    eb = model_step(m_b, 1'b0);
    exp_q.push_back(ea);
    exp_q.push_back(eb);
    m_a = ea;
    m_b = eb;
    @(posedge clock);
    #1;
    if (exp_q.size() < 2) begin
      check_val("scoreboard.depth", 32'(exp_q.size()), 32'd2);
    end else begin
      ea = exp_q.pop_front();
      eb = exp_q.pop_front();
      cmp_outs("sticky", ea, a_block, a_deadlock, a_state, a_cause, a_bc, a_evt);
      cmp_outs("nonsticky", eb, b_block, b_deadlock, b_state, b_cause, b_bc, b_evt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    m_a = '0; m_b = '0;
    reset = 1'b1; clear = 1'b0; axis = 2'b00; sub = 3'b000; idle = 5'b00000; thr = 4'd4;
    repeat (3) step_cycle();
    check_val("reset.state", 32'(a_state), 32'd0);
    check_val("reset.event_count", 32'(a_evt), 32'd0);
    reset = 1'b0;
    step_cycle();

    // Persistent stream block with threshold 4: deadlock exactly 4 edges after raw rises.
    axis = 2'b10;
    for (int n = 1; n <= 6; n++) begin
      step_cycle();
      check_val("p1.block", 32'(a_block), 32'd1);
      check_val("p1.deadlock", 32'(a_deadlock), 32'(n >= 4));
      check_val("p1.state", 32'(a_state), (n >= 4) ? 32'd2 : 32'd1);
      check_val("p1.nsdeadlock", 32'(b_deadlock), 32'(n >= 4));
    end
    check_val("p1.cause", 32'(a_cause), 32'b010);
    check_val("p1.event_count", 32'(a_evt), 32'd1);
    axis = 2'b00;
    repeat (3) begin
      step_cycle();
      check_val("p1.sticky_hold", 32'(a_deadlock), 32'd1);
      check_val("p1.nonsticky_drop", 32'(b_state), 32'd0);
    end
    clear = 1'b1;
    step_cycle();
    clear = 1'b0;
    check_val("p1.clear_deadlock", 32'(a_deadlock), 32'd0);
    check_val("p1.clear_state", 32'(a_state), 32'd0);
    check_val("p1.clear_keeps_evt", 32'(a_evt), 32'd1);

    // Three raw cycles then one quiet cycle aborts the suspicion.
    axis = 2'b01;
    repeat (3) begin
      step_cycle();
      check_val("p2.no_deadlock", 32'(a_deadlock), 32'd0);
    end
    axis = 2'b00;
    step_cycle();
    check_val("p2.state", 32'(a_state), 32'd0);
    check_val("p2.block_cycles", 32'(a_bc), 32'd0);

    // All processes idle masks every block source.
    idle = 5'b11111; axis = 2'b11;
    repeat (20) begin
      step_cycle();
      check_val("p3.block", 32'(a_block), 32'd0);
      check_val("p3.state", 32'(a_state), 32'd0);
    end
    idle = 5'b00000; axis = 2'b00;
    step_cycle();

    // Full sub-monitor agreement with threshold 0 deadlocks after one edge.
    thr = 4'd0; sub = 3'b111;
    step_cycle();
    check_val("p4.deadlock", 32'(a_deadlock), 32'd1);
    check_val("p4.cause", 32'(a_cause), 32'b100);
    check_val("p4.event_count", 32'(a_evt), 32'd2);
    sub = 3'b000; clear = 1'b1;
    step_cycle();
    clear = 1'b0;
    sub = 3'b011;
    repeat (3) begin
      step_cycle();
      check_val("p4.partial_sub", 32'(a_block), 32'd0);
    end
    sub = 3'b000;

    // Long block saturates the 4-bit persistence counter; reset mid-run clears everything.
    thr = 4'd3; axis = 2'b01;
    repeat (40) step_cycle();
    check_val("p5.sat_sticky", 32'(a_bc), 32'd15);
    check_val("p5.sat_nonsticky", 32'(b_bc), 32'd15);
    reset = 1'b1;
    step_cycle();
    check_val("p5.rst_block", 32'(a_block), 32'd0);
    check_val("p5.rst_state", 32'(a_state), 32'd0);
    check_val("p5.rst_bc", 32'(a_bc), 32'd0);
    check_val("p5.rst_evt", 32'(a_evt), 32'd0);
    reset = 1'b0; axis = 2'b00;
    step_cycle();

    // Clear coinciding with the DEADLOCK-entry cycle wins and does not count an event.
    thr = 4'd2; axis = 2'b01;
    step_cycle();
    clear = 1'b1;
    step_cycle();
    clear = 1'b0;
    check_val("p6.state", 32'(a_state), 32'd0);
    check_val("p6.event_count", 32'(a_evt), 32'd0);
    axis = 2'b00;
    step_cycle();

    // Randomised run with bursty blocks, occasional clears and changing thresholds.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) axis = 2'($urandom);
      if ($urandom_range(0, 6) == 0) sub = ($urandom_range(0, 1) == 0) ? 3'b111 : 3'($urandom);
      idle  = ($urandom_range(0, 9) == 0) ? 5'b11111 : 5'($urandom);
      if ($urandom_range(0, 7) == 0) thr = 4'($urandom_range(0, 5));
      clear = ($urandom_range(0, 24) == 0);
      step_cycle();
    end
    clear = 1'b0;

    check_val("scoreboard.drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule

// File: doc/adc_capture_deadlock_watchdog.md
# adc_capture_deadlock_watchdog

Parametrised deadlock watchdog for the ADC capture dataflow. It generalises the per-process HLS deadlock monitor to N AXI-stream channels and M sub-monitors. It suppresses reports while the whole design is idle, and only declares a deadlock after the block condition has held for a programmable number of consecutive cycles. It sits beside the capture dataflow region and feeds the status/interrupt logic with a registered block flag, a sticky deadlock flag, the captured cause and an event count.

## Interface
Parameters:
- N_AXIS, 2, number of AXI-stream block inputs (≥1)
- N_SUB, 3, number of sub-monitor block inputs (≥0; 0 disables the sub term)
- N_INST, 5, number of process idle inputs (≥1)
- CNT_W, 16, width of threshold and persistence counter
- STICKY, 1, 1 = deadlock held until clear; 0 = deadlock drops when the condition drops

Ports (reset: reset, synchronous, active-high; clock: clock):
- clock  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- axis_block_sigs  in  N_AXIS  per-channel stream block
- sub_block_sigs  in  max(N_SUB,1)  sub-monitor block flags (ignored when N_SUB=0)
- inst_idle_sigs  in  N_INST  per-process idle
- threshold  in  CNT_W  consecutive cycles required; 0 treated as 1
- clear  in  1  one-cycle pulse, clears deadlock/state/cause
- block  out  1  registered raw condition (legacy-compatible)
- deadlock  out  1  state==DEADLOCK
- state  out  2  0 IDLE, 1 SUSPECT, 2 DEADLOCK
- cause  out  N_AXIS+1  {sub_term, axis_block_sigs} snapshot at IDLE exit
- block_cycles  out  CNT_W  persistence counter, saturating
- event_count  out  8  saturating count of DEADLOCK entries

## Operation
- any_axis = |axis_block_sigs.
- sub_term = (N_SUB>0) & (&sub_block_sigs).
- all_idle = &inst_idle_sigs.
- raw = (any_axis | sub_term) & ~all_idle.
- block <= raw every cycle.
- Teff = max(threshold,1).
- IDLE:
  - raw & Teff==1 → DEADLOCK, cnt=1.
  - raw & Teff>1 → SUSPECT, cnt=1.
  - On either exit, cause <= {sub_term, axis_block_sigs}.
  - ~raw → stay, cnt=0.
- SUSPECT:
  - ~raw → IDLE, cnt=0, cause=0.
  - raw & cnt+1≥Teff → DEADLOCK.
  - Otherwise stay.
  - cnt increments on every raw cycle.
- DEADLOCK:
  - cnt keeps incrementing on raw and saturates at 2^CNT_W−1.
  - STICKY=0 & ~raw → IDLE, cnt=0, cause=0.
  - STICKY=1 → hold until clear; cnt holds on ~raw.
- event_count increments on every transition into DEADLOCK and saturates at 255. Only reset clears it; clear does not.
- clear (priority below reset, above everything else):
  - state=IDLE, cnt=0, cause=0.
  - block still updates from raw.
  - raw in the clear cycle is ignored by the FSM; re-evaluation starts next cycle.
- threshold is sampled every cycle. Lowering it while in SUSPECT can trigger DEADLOCK on the next raw cycle.

## Timing
- Reset values: block=0, deadlock=0, state=0, cause=0, block_cycles=0, event_count=0.
- block latency: 1 cycle from raw.
- raw first high at cycle t and held → deadlock high at t+Teff.
- A single ~raw cycle before t+Teff−1 aborts: state returns to IDLE and cnt=0 at the following edge.
- all_idle high masks raw in the same cycle, i.e. it counts as a ~raw cycle.
- Reset mid-SUSPECT or mid-DEADLOCK returns all outputs to reset values at the next edge.
- Simultaneous clear and DEADLOCK-entry condition: clear wins, and event_count does not increment.

## Structure
- Shared package adc_capture_pkg:
  - state enum (IDLE/SUSPECT/DEADLOCK, 2 bits)
  - default CNT_W constant
- One natural sub-module: adc_capture_block_reduce. It is combinational and computes raw from the three input vectors. It is reusable by the per-process legacy monitors.
- The FSM, counters and cause register stay in the top.

## Test plan
- N_AXIS=2, threshold=4, axis_block_sigs=2'b10 held from cycle 10 → block=1 at 11, state=SUSPECT at 11, deadlock=1 at 14, cause=3'b010, event_count=1.
- threshold=4, raw high cycles 10–12, low at 13 → deadlock never set, state=IDLE at 14, block_cycles=0.
- All inst_idle_sigs=1 with axis_block_sigs=2'b11 for 20 cycles → block=0 and state=IDLE throughout.
- STICKY=1, deadlock reached, raw drops → deadlock stays 1. clear pulse at cycle c → deadlock=0 and state=IDLE at c+1.
- N_SUB=3:
  - sub_block_sigs=3'b111, threshold=0 → deadlock one cycle after raw, cause=3'b100.
  - sub_block_sigs=3'b011 alone → no block.
- threshold=3, CNT_W=4, raw held 40 cycles → block_cycles saturates at 15. Reset asserted mid-run → all outputs 0 next edge.
